// File: rtl/memory_fetcher.sv
// Weight/bias fetch stage: streams one BRAM row (N weights + bias) per enabled
// clock to the MAC array, wrapping from row M-1 back to row 0.
module memory_fetcher #(
    parameter int    BRAM_WIDTH     = 64,
    parameter int    M              = 6,
    parameter int    N              = 4,
    parameter int    BIAS_PRECISION = 32,
    parameter int    PRECISION      = 8,
    parameter string INIT_FILE      = ""
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ce,
    output logic [N-1:0][PRECISION-1:0]       data_out,
    output logic [BIAS_PRECISION-1:0]         bias,
    output logic                              in_ready
);

    localparam int ADDR_W   = (M > 1) ? $clog2(M) : 1;
    localparam int WEIGHT_W = N * PRECISION;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M - 1);

    generate
        if (BRAM_WIDTH < WEIGHT_W + BIAS_PRECISION) begin : g_width_check
            $error("memory_fetcher: BRAM_WIDTH too small for N*PRECISION + BIAS_PRECISION");
        end
    endgenerate

    function automatic logic [BRAM_WIDTH-1:0] build_word(input int r);
        logic [BRAM_WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < N; k++) begin
            w[k*PRECISION +: PRECISION] = PRECISION'(r * N + k + 1);
        end
        w[WEIGHT_W +: BIAS_PRECISION] = BIAS_PRECISION'(256 * (r + 1));
        return w;
    endfunction

    logic [BRAM_WIDTH-1:0] mem [0:M-1];

    generate
        for (genvar r = 0; r < M; r++) begin : g_row
            assign mem[r] = build_word(r);
        end
    endgenerate

    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [N-1:0][PRECISION-1:0]  data_q, data_d;
    logic [BIAS_PRECISION-1:0]    bias_q, bias_d;
    logic                         ready_q, ready_d;
    logic [BRAM_WIDTH-1:0]        row_word;

    assign row_word = mem[addr_q];

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        bias_d  = bias_q;
        ready_d = 1'b0;
        if (ce) begin
            for (int k = 0; k < N; k++) begin
                data_d[k] = row_word[k*PRECISION +: PRECISION];
            end
            bias_d  = row_word[WEIGHT_W +: BIAS_PRECISION];
            ready_d = 1'b1;
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            bias_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            bias_q  <= bias_d;
            ready_q <= ready_d;
        end
    end

    assign data_out = data_q;
    assign bias     = bias_q;
    assign in_ready = ready_q;

endmodule

// File: tb/tb_memory_fetcher.sv
// Bench for memory_fetcher: directed test-plan steps then random ce/rst traffic,
// checked against a row-index model of the layer image.
module tb_memory_fetcher;

    localparam int M  = 6;
    localparam int N  = 4;
    localparam int P  = 8;
    localparam int BP = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  ce  = 1'b0;
    logic [N-1:0][P-1:0]   data_out;
    logic [BP-1:0]         bias;
    logic                  in_ready;

    int total = 0;
    int bad   = 0;

    // Model: which row is displayed (-1 = cleared) and which row comes next.
    int shown_row = -1;
    int next_row  = 0;
    bit exp_ready = 1'b0;

    memory_fetcher #(
        .BRAM_WIDTH(64), .M(M), .N(N), .BIAS_PRECISION(BP), .PRECISION(P), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .data_out(data_out), .bias(bias), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [P-1:0] exp_weight(input int row, input int k);
        if (row < 0) return '0;
        return P'((row * N + k + 1) % 256);
    endfunction

    function automatic logic [BP-1:0] exp_bias(input int row);
        if (row < 0) return '0;
        return BP'(256 * (row + 1));
    endfunction

    task automatic check_all(input string tag);
        total++;
        assert (in_ready === exp_ready) else begin
            bad++;
            $error("FAIL %s in_ready got=%0b want=%0b", tag, in_ready, exp_ready);
        end
        total++;
        assert (bias === exp_bias(shown_row)) else begin
            bad++;
            $error("FAIL %s bias got=%0d want=%0d", tag, bias, exp_bias(shown_row));
        end
        for (int k = 0; k < N; k++) begin
            total++;
            assert (data_out[k] === exp_weight(shown_row, k)) else begin
                bad++;
                $error("FAIL %s lane%0d got=%0d want=%0d", tag, k, data_out[k],
                       exp_weight(shown_row, k));
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input string tag);
        @(negedge clk);
        rst = r;
        ce  = c;
        @(posedge clk);
        if (r) begin
            shown_row = -1;
            next_row  = 0;
            exp_ready = 1'b0;
        end else if (c) begin
            shown_row = next_row;
            next_row  = (next_row + 1) % M;
            exp_ready = 1'b1;
        end else begin
            exp_ready = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic check_const(input string tag, input logic [N*P-1:0] lanes,
                               input logic [BP-1:0] b);
        total++;
        assert (data_out === lanes && bias === b && in_ready === 1'b1) else begin
            bad++;
            $error("FAIL %s got lanes=%h bias=%0d rdy=%0b want lanes=%h bias=%0d rdy=1",
                   tag, data_out, bias, in_ready, lanes, b);
        end
    endtask

    initial begin
        step(1'b1, 1'b0, "reset0");
        step(1'b1, 1'b0, "reset1");

        step(1'b0, 1'b1, "first");
        check_const("first_const", {8'd4, 8'd3, 8'd2, 8'd1}, 32'd256);
        for (int i = 1; i < M; i++) step(1'b0, 1'b1, "stream");
        check_const("row5_const", {8'd24, 8'd23, 8'd22, 8'd21}, 32'd1536);
        step(1'b0, 1'b1, "wrap");
        check_const("wrap_const", {8'd4, 8'd3, 8'd2, 8'd1}, 32'd256);

        step(1'b0, 1'b1, "row1");
        step(1'b0, 1'b1, "row2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "stall");
        step(1'b0, 1'b1, "resume");
        check_const("resume_const", {8'd16, 8'd15, 8'd14, 8'd13}, 32'd1024);

        step(1'b0, 1'b1, "row4");
        step(1'b1, 1'b1, "mid_reset");
        step(1'b0, 1'b1, "after_reset");
        check_const("after_reset_const", {8'd4, 8'd3, 8'd2, 8'd1}, 32'd256);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
